cle_label_checker: RTL and testbench
====================================

# cle_label_checker

Synthesizable, parametrised result checker for the component labeling engine. After a labeling run it scans the engine's result SRAM and a golden label memory in lock-step over an IMG_W×IMG_H image. It checks that background matches exactly and that golden objects map one-to-one onto result labels, then reports an error count, the first failing address and pass/fail. It sits beside the CLE core on the same clock, driving the read ports of both memories through its own address buses, and supports on-chip self-test of the labeling datapath.

## Interface
- IMG_W, 32: image width in pixels.
- IMG_H, 32: image height in pixels.
- AW, 10: address width; must satisfy 2^AW ≥ IMG_W·IMG_H.
- LBL_W, 8: label width.
- MAX_OBJ, 8: number of golden labels tracked; valid golden labels are 1..MAX_OBJ.
- ERR_W, 11: width of the error counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- test_se  in  1  scan enable; no functional effect.
- start  in  1  begins a check; sampled only in IDLE.
- res_a  out  AW  result SRAM read address.
- res_q  in  LBL_W  result SRAM read data; one-cycle synchronous read.
- gold_a  out  AW  golden memory read address; always equal to res_a.
- gold_q  in  LBL_W  golden memory read data; one-cycle synchronous read.
- busy  out  1  high from the start-sampling edge until done rises.
- done  out  1  level; held high until the next accepted start.
- pass  out  1  valid while done; 1 when err_cnt == 0.
- err_cnt  out  ERR_W  count of failing pixels; saturates at 2^ERR_W−1.
- first_err_a  out  AW  address of the first failing pixel.
- first_err_v  out  1  first_err_a is valid.

## Operation
- States: IDLE → RUN → DRAIN → DONE → (start) RUN.
- IDLE/DONE with start=1: clear err_cnt, first_err_v, the map table and done. Enter RUN.
- RUN: drive address a = 0..N−1 (N = IMG_W·IMG_H), incrementing once per cycle. After N−1 is issued, go to DRAIN.
- DRAIN: consume the last pixel, then enter DONE.
- Pipeline: data for the address driven in cycle t is evaluated on the edge that ends cycle t+1. A 1-bit valid and the AW-bit pixel address are delayed in step with the read.
- Map table: MAX_OBJ entries, each holding {valid, LBL_W label}, indexed by golden label g.
- Per pixel (g = gold_q, r = res_q), the pixel is an error if any of these holds:
  - g == 0 and r != 0.
  - g != 0 and r == 0.
  - g > MAX_OBJ.
  - The entry for g is valid and its label != r.
  - The entry for g is invalid and r equals the label of any other valid entry. This is a merge, found by a parallel compare of all entries.
- Otherwise, if the entry for g is invalid, write {1, r} into it.
- An erroring first occurrence does not write the table; the next pixel of the same golden object retries.
- On each error: err_cnt += 1, saturating. If first_err_v == 0, latch the pixel address and set first_err_v.
- start in RUN or DRAIN is ignored.
- Address outputs hold 0 in IDLE and hold their last value in DONE.

## Timing
- Reset values: res_a = gold_a = 0, busy = 0, done = 0, pass = 0, err_cnt = 0, first_err_a = 0, first_err_v = 0, state IDLE, map table all invalid.
- The edge that samples start is E0. Address 0 is driven in the cycle after E0, and address k in the cycle after edge E0+k.
- The last evaluation happens on edge E0+N+1. done and pass rise after edge E0+N+2, and busy falls on that same edge.
- Reset asserted mid-run aborts immediately to the reset values; no partial results remain.
- A table write and a merge compare for the same pixel resolve within one cycle. A write made for pixel k is visible to pixel k+1.

## Test plan
- Golden image with objects labeled 1,2,3; result identical except labels permuted to 0x07, 0x02, 0x40. Required: done, pass=1, err_cnt=0, first_err_v=0.
- One background pixel at address 37 set to 0x05 in the result. Required: err_cnt=1, first_err_a=37, pass=0.
- Golden object 2 split into labels 0x11/0x12, with 6 pixels carrying the second label, not at the first occurrence. Required: err_cnt=6.
- Golden objects 1 and 2 both labeled 0x09 in the result, object 2 having 20 pixels. Required: err_cnt=20 (merge).
- Golden label MAX_OBJ+1 on 4 pixels. Required: err_cnt=4. Then start pulsed again with clean images. Required: counters cleared, pass=1, done exactly N+2 edges after the start edge.
- reset pulsed at address 500 of a run. Required: all outputs return to their reset values asynchronously. A new start completes normally. With ERR_W=3 and 10 errors, err_cnt=7.

Source files
------------

// File: rtl/cle_label_checker.sv
// Scans a result label memory against a golden label memory. It checks background
// equality and a one-to-one mapping of golden objects to result labels.
module cle_label_checker #(
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int AW      = 10,
    parameter int LBL_W   = 8,
    parameter int MAX_OBJ = 8,
    parameter int ERR_W   = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             test_se,
    input  logic             start,
    output logic [AW-1:0]    res_a,
    input  logic [LBL_W-1:0] res_q,
    output logic [AW-1:0]    gold_a,
    input  logic [LBL_W-1:0] gold_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [AW-1:0]    first_err_a,
    output logic             first_err_v
);

    localparam int N = IMG_W * IMG_H;
    localparam logic [AW-1:0] LAST_A = AW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t               state;
    logic [AW-1:0]        addr;
    logic                 pix_v;
    logic [AW-1:0]        pix_a;

    logic                 accept;
    logic [MAX_OBJ-1:0]   map_v;
    logic [LBL_W-1:0]     map_l [MAX_OBJ];
    logic [MAX_OBJ-1:0]   hit;
    logic [MAX_OBJ-1:0]   other;
    logic                 sel_v;
    logic [LBL_W-1:0]     sel_l;
    logic                 pix_err;
    logic                 tbl_wr;

    // Scan enable is only consumed by inserted scan chains.
    logic unused_test_se;
    assign unused_test_se = test_se;

    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign res_a  = addr;
    assign gold_a = addr;

    // One map entry per golden label; entry gi belongs to golden label gi+1.
    generate
        for (genvar gi = 0; gi < MAX_OBJ; gi++) begin : g_ent
            logic             ent_v;
            logic [LBL_W-1:0] ent_l;

            assign hit[gi]   = (gold_q == LBL_W'(gi + 1));
            assign other[gi] = ent_v && !hit[gi] && (ent_l == res_q);
            assign map_v[gi] = ent_v;
            assign map_l[gi] = ent_l;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ent_v <= 1'b0;
                    ent_l <= '0;
                end else if (accept) begin
                    ent_v <= 1'b0;
                end else if (tbl_wr && hit[gi]) begin
                    ent_v <= 1'b1;
                    ent_l <= res_q;
                end
            end
        end
    endgenerate

    always_comb begin
        sel_v = 1'b0;
        sel_l = '0;
        for (int i = 0; i < MAX_OBJ; i++) begin
            if (hit[i]) begin
                sel_v = map_v[i];
                sel_l = map_l[i];
            end
        end
    end

    always_comb begin
        pix_err = 1'b0;
        if (gold_q == '0)
            pix_err = (res_q != '0);
        else if (res_q == '0)
            pix_err = 1'b1;
        else if (int'(gold_q) > MAX_OBJ)
            pix_err = 1'b1;
        else if (sel_v)
            pix_err = (sel_l != res_q);
        else
            pix_err = |other;   // unmapped object reusing another object's label
    end

    // A first occurrence that errors leaves its entry empty so the next pixel retries.
    assign tbl_wr = pix_v && !pix_err && (gold_q != '0) && !sel_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            addr        <= '0;
            pix_v       <= 1'b0;
            pix_a       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_cnt     <= '0;
            first_err_a <= '0;
            first_err_v <= 1'b0;
        end else begin
            pix_v <= (state == S_RUN);
            pix_a <= addr;

            if (pix_v && pix_err) begin
                if (err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
                if (!first_err_v) begin
                    first_err_a <= pix_a;
                    first_err_v <= 1'b1;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RUN;
                        addr        <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        err_cnt     <= '0;
                        first_err_v <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (addr == LAST_A)
                        state <= S_DRAIN;
                    else
                        addr <= addr + 1'b1;
                end
                S_DRAIN: begin
                    // Wait until the last pixel has been evaluated.
                    if (!pix_v) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cle_label_checker.sv
// Scoreboard bench for cle_label_checker: two instances (wide and 3-bit error
// counters) read shared image memories; a monitor checks each completed run.
module tb_cle_label_checker;

    localparam int N = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       test_se = 1'b0;
    logic       start = 1'b0;

    logic [9:0]  res_a1, gold_a1, first_a1, res_a2, gold_a2, first_a2;
    logic [7:0]  res_q1, gold_q1, res_q2, gold_q2;
    logic        busy1, done1, pass1, fv1, busy2, done2, pass2, fv2;
    logic [10:0] err1;
    logic [2:0]  err2;

    logic [7:0] res_mem  [N];
    logic [7:0] gold_mem [N];

    typedef struct {
        string name;
        int    err;
        bit    fv;
        int    fa;
        longint e0;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    logic   done_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        res_q1  <= res_mem[res_a1];
        gold_q1 <= gold_mem[gold_a1];
        res_q2  <= res_mem[res_a2];
        gold_q2 <= gold_mem[gold_a2];
    end

    cle_label_checker dut1 (
        .clk(clk), .reset(reset), .test_se(test_se), .start(start),
        .res_a(res_a1), .res_q(res_q1), .gold_a(gold_a1), .gold_q(gold_q1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_a(first_a1), .first_err_v(fv1)
    );

    cle_label_checker #(.ERR_W(3)) dut2 (
        .clk(clk), .reset(reset), .test_se(test_se), .start(start),
        .res_a(res_a2), .res_q(res_q2), .gold_a(gold_a2), .gold_q(gold_q2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_err_a(first_a2), .first_err_v(fv2)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: on each rising done, pop the expected outcome and compare.
    always @(negedge clk) begin
        if (done1 && !done_q) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("run %s: err_cnt=%0d err_cnt_w3=%0d first_v=%0b first_a=%0d pass=%0b edges=%0d",
                         mon_e.name, err1, err2, fv1, first_a1, pass1, cyc - mon_e.e0);
                chk({mon_e.name, "_err_cnt"}, err1, mon_e.err);
                chk({mon_e.name, "_err_cnt_w3"}, err2, (mon_e.err > 7) ? 7 : mon_e.err);
                chk({mon_e.name, "_pass"}, pass1, (mon_e.err == 0) ? 1 : 0);
                chk({mon_e.name, "_pass_w3"}, pass2, (mon_e.err == 0) ? 1 : 0);
                chk({mon_e.name, "_first_v"}, fv1, mon_e.fv);
                if (mon_e.fv)
                    chk({mon_e.name, "_first_a"}, first_a1, mon_e.fa);
                chk({mon_e.name, "_done_edges"}, cyc - mon_e.e0, N + 2);
                chk({mon_e.name, "_busy_low"}, busy1, 0);
                chk({mon_e.name, "_done_w3"}, done2, 1);
            end
        end
        done_q <= done1;
    end

    task automatic set_rect(input int g, input int r, input int r0, input int r1,
                            input int c0, input int c1);
        for (int y = r0; y <= r1; y++)
            for (int x = c0; x <= c1; x++) begin
                gold_mem[y*32 + x] = 8'(g);
                res_mem[y*32 + x]  = 8'(r);
            end
    endtask

    task automatic build_base(input int l1, input int l2, input int l3);
        for (int i = 0; i < N; i++) begin
            gold_mem[i] = 8'h00;
            res_mem[i]  = 8'h00;
        end
        set_rect(1, l1, 2, 5, 2, 5);        // 16 px, first at 66
        set_rect(2, l2, 10, 14, 10, 13);    // 20 px, first at 330
        set_rect(3, l3, 20, 22, 20, 29);    // 30 px, first at 660
    endtask

    task automatic start_pulse(output longint e0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic run(input string nm, input int err, input bit fv, input int fa);
        exp_t   e;
        longint e0;
        int     n;
        start_pulse(e0);
        e.name = nm; e.err = err; e.fv = fv; e.fa = fa; e.e0 = e0;
        exp_q.push_back(e);
        chk({nm, "_busy_high"}, busy1, 1);
        n = 0;
        while (!done1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done1)
            chk({nm, "_done_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        longint e0;
        int     n;

        build_base(8'h07, 8'h02, 8'h40);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_res_a", res_a1, 0);
        chk("rst_gold_a", gold_a1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_err_cnt", err1, 0);
        chk("rst_first_a", first_a1, 0);
        chk("rst_first_v", fv1, 0);

        test_se = 1'b1;
        run("permuted", 0, 0, 0);
        test_se = 1'b0;
        chk("done_hold_addr", res_a1, N - 1);

        build_base(8'h07, 8'h02, 8'h40);
        res_mem[37] = 8'h05;
        run("bg37", 1, 1, 37);

        build_base(8'h07, 8'h11, 8'h40);
        for (int x = 10; x <= 13; x++) res_mem[14*32 + x] = 8'h12;
        res_mem[13*32 + 12] = 8'h12;
        res_mem[13*32 + 13] = 8'h12;
        run("split", 6, 1, 428);

        build_base(8'h09, 8'h09, 8'h40);
        run("merge", 20, 1, 330);

        build_base(8'h07, 8'h02, 8'h40);
        for (int i = 960; i <= 963; i++) begin
            gold_mem[i] = 8'd9;
            res_mem[i]  = 8'h33;
        end
        run("label9", 4, 1, 960);

        build_base(8'h07, 8'h02, 8'h40);
        run("clean_again", 0, 0, 0);

        // Abort a run that has already recorded an error.
        res_mem[37] = 8'h05;
        start_pulse(e0);
        n = 0;
        while (res_a1 != 10'd500 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_addr500", res_a1, 500);
        #1 reset = 1'b1;
        #1;
        chk("arst_res_a", res_a1, 0);
        chk("arst_busy", busy1, 0);
        chk("arst_done", done1, 0);
        chk("arst_pass", pass1, 0);
        chk("arst_err_cnt", err1, 0);
        chk("arst_first_a", first_a1, 0);
        chk("arst_first_v", fv1, 0);
        chk("arst_err_cnt_w3", err2, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        res_mem[37] = 8'h00;
        run("after_reset", 0, 0, 0);

        build_base(8'h07, 8'h02, 8'h40);
        for (int i = 40; i <= 44; i++) res_mem[i] = 8'h05;
        for (int i = 729; i <= 733; i++) res_mem[i] = 8'h00;
        run("ten_errs", 10, 1, 40);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
